// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// The source drives i/i_valid; the serializer drives everything else.
interface piso_serializer_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] i;
    logic             i_valid;
    logic             i_ready;
    logic             o;
    logic             o_valid;
    logic             busy;

    modport master (
        output i, i_valid,
        input  i_ready, o, o_valid, busy
    );

    modport slave (
        input  i, i_valid,
        output i_ready, o, o_valid, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: WIDTH-bit word in over valid/ready, LSB-first bits out.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    piso_serializer_if.slave  bus
);
    localparam int                CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0] count;
    logic             last_cycle;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity;
`endif

    assign shreg_next = shreg >> 1;

    // The final output cycle of a word is where the next word may be taken.
`ifdef PISO_PARITY_EN
    assign last_cycle = (state == PARITY);
`else
    assign last_cycle = (state == SHIFT) && (count == LAST);
`endif

    assign bus.i_ready = !reset && ((state == IDLE) || last_cycle);
    assign accept      = bus.i_valid && bus.i_ready;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            count       <= '0;
            bus.o       <= 1'b0;
            bus.o_valid <= 1'b0;
            bus.busy    <= 1'b0;
`ifdef PISO_PARITY_EN
            parity      <= 1'b0;
`endif
        end else if (accept) begin
            state       <= SHIFT;
            shreg       <= bus.i;
            count       <= '0;
            bus.o       <= bus.i[0];
            bus.o_valid <= 1'b1;
            bus.busy    <= 1'b1;
`ifdef PISO_PARITY_EN
            parity      <= ^bus.i;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    shreg <= shreg_next;
                    if (count == LAST) begin
                        count <= '0;
`ifdef PISO_PARITY_EN
                        state       <= PARITY;
                        bus.o       <= parity;
                        bus.o_valid <= 1'b1;
                        bus.busy    <= 1'b1;
`else
                        state       <= IDLE;
                        bus.o       <= 1'b0;
                        bus.o_valid <= 1'b0;
                        bus.busy    <= 1'b0;
`endif
                    end else begin
                        count       <= count + 1'b1;
                        bus.o       <= shreg_next[0];
                        bus.o_valid <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state       <= IDLE;
                    bus.o       <= 1'b0;
                    bus.o_valid <= 1'b0;
                    bus.busy    <= 1'b0;
                end
`endif
                default: begin
                    state       <= IDLE;
                    bus.o       <= 1'b0;
                    bus.o_valid <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule
